sisc_ifetch: RTL and testbench

Instruction-fetch and branch unit for the SISC processor; the responder side of the control FSM's fetch/branch interface. It holds the PC and instruction register (IR), runs a req/ack read on instruction memory when the control unit pulses `fetch_go`, and presents `opcode`/`mm` back to the control unit. During execute it evaluates BRA/BRR/BNE/BNR against the status register and redirects the PC.

---
 rtl/sisc_ifetch.sv | 100 ++++++++++
 tb/tb_sisc_ifetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: SISC instruction fetch and branch unit; holds PC/IR, runs a
// req/ack read on instruction memory and resolves BRA/BRR/BNE/BNR.
// Optional fetch timeout is enabled by defining SISC_IFETCH_TIMEOUT_EN.
module sisc_ifetch #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_go,
  input  logic              br_eval,
  input  logic [3:0]        stat,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              br_taken,
  output logic              halted,
  output logic              fetch_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic br_ok, take, c;
  logic [ADDR_W-1:0] rel, target;
`ifdef SISC_IFETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic expire;
  // WAIT gives up once the counter would reach TIMEOUT_CYC without an ack
  always_comb expire = !imem_ack && cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign fetch_err = 1'b0;
`endif
  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign busy   = state == WAIT;
  // Branch decode: opcodes 4..7, bit1 inverts the condition, bit0 selects PC-relative
  always_comb begin
    c      = |(stat & mm);
    br_ok  = state == IDLE && ir_valid && br_eval;
    take   = br_ok && opcode[3:2] == 2'b01 && (opcode[1] ? !c : c);
    rel    = ADDR_W'($signed(ir[15:0]));
    target = opcode[0] ? pc + rel : ir[ADDR_W-1:0];
  end
  // Fetch FSM with registered outputs; an accepted branch wins over a same-cycle fetch
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      br_taken  <= 1'b0;
      halted    <= 1'b0;
`ifdef SISC_IFETCH_TIMEOUT_EN
      cnt       <= '0;
      fetch_err <= 1'b0;
`endif
    end else begin
      br_taken <= take;
      if (take) pc <= target;
      if (state == IDLE) begin
        if (fetch_go && !halted && !br_ok) begin
          state     <= WAIT;
          imem_req  <= 1'b1;
          imem_addr <= pc;
          ir_valid  <= 1'b0;
`ifdef SISC_IFETCH_TIMEOUT_EN
          cnt       <= '0;
          fetch_err <= 1'b0;
`endif
        end
      end else if (imem_ack) begin
        state    <= IDLE;
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
        pc       <= pc + 1'b1;
        imem_req <= 1'b0;
        if (&imem_rdata[31:28]) halted <= 1'b1;
      end
`ifdef SISC_IFETCH_TIMEOUT_EN
      else if (expire) begin
        state     <= IDLE;
        imem_req  <= 1'b0;
        ir        <= '0;
        ir_valid  <= 1'b1;
        fetch_err <= 1'b1;
      end else cnt <= cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: scoreboard bench for sisc_ifetch fetch, branch, halt and reset behaviour.
module tb_sisc_ifetch;
  logic clk = 0, rst_f = 0, fetch_go = 0, br_eval = 0, imem_ack = 0;
  logic [3:0] stat = 0;
  logic [31:0] imem_rdata = 0;
  logic [15:0] imem_addr, pc;
  logic imem_req, ir_valid, busy, br_taken, halted, fetch_err;
  logic [31:0] ir;
  logic [3:0] opcode, mm;
  typedef struct {logic [31:0] ir; logic [15:0] pc;} exp_t;
  exp_t sb[$];
  logic [15:0] pc_m = 0;
  int checks = 0, failures = 0;

  sisc_ifetch dut (
    .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_eval(br_eval), .stat(stat),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opcode(opcode), .mm(mm), .ir_valid(ir_valid), .pc(pc), .busy(busy),
    .br_taken(br_taken), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data, input int dly);
    exp_t e;
    sb.push_back('{data, pc_m + 16'd1});
    fetch_go = 1;
    step();
    fetch_go = 0;
    check("req_on", 32'(imem_req), 1);
    check("addr", 32'(imem_addr), 32'(pc_m));
    for (int i = 0; i < dly; i++) begin
      check("busy_wait", 32'(busy), 1);
      fetch_go = 1;
      br_eval = 1;
      step();
      fetch_go = 0;
      br_eval = 0;
    end
    check("busy_ack", 32'(busy), 1);
    imem_ack = 1;
    imem_rdata = data;
    step();
    imem_ack = 0;
    e = sb.pop_front();
    pc_m = e.pc;
    check("ir", ir, e.ir);
    check("pc_inc", 32'(pc), 32'(pc_m));
    check("ir_valid", 32'(ir_valid), 1);
    check("opcode", 32'(opcode), 32'(e.ir[31:28]));
    check("mm", 32'(mm), 32'(e.ir[27:24]));
    check("req_off", 32'(imem_req), 0);
    check("busy_off", 32'(busy), 0);
  endtask

  task automatic branch(input logic [3:0] s, input logic tk, input logic [15:0] tgt);
    stat = s;
    br_eval = 1;
    step();
    br_eval = 0;
    if (tk) pc_m = tgt;
    check("br_pc", 32'(pc), 32'(pc_m));
    check("br_taken", 32'(br_taken), 32'(tk));
    step();
    check("br_taken_low", 32'(br_taken), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    check("rst_pc", 32'(pc), 0);
    check("rst_ir", ir, 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_br_taken", 32'(br_taken), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fetch_err", 32'(fetch_err), 0);
    rst_f = 1;
    step();
    fetch(32'h8812_0005, 0);
    fetch(32'h4200_000A, 0);
    branch(4'b0010, 1, 16'h000A);
    branch(4'b0001, 0, 16'h0000);
    stat = 4'b0001;
    fetch_go = 1;
    br_eval = 1;
    step();
    fetch_go = 0;
    br_eval = 0;
    check("drop_req", 32'(imem_req), 0);
    check("drop_busy", 32'(busy), 0);
    check("drop_pc", 32'(pc), 32'(pc_m));
    fetch(32'h4100_000F, 0);
    branch(4'b0001, 1, 16'h000F);
    fetch(32'h5F00_FFFC, 0);
    check("pc_10", 32'(pc), 32'h10);
    branch(4'b0001, 1, 16'h000C);
    fetch(32'h7F00_FFFC, 0);
    branch(4'b0001, 0, 16'h0000);
    fetch(32'h6200_0030, 5);
    step();
    check("one_fetch_req", 32'(imem_req), 0);
    branch(4'b0001, 1, 16'h0030);
    imem_ack = 1;
    imem_rdata = 32'hF000_0000;
    step();
    imem_ack = 0;
    check("stray_ack_ir", ir, 32'h6200_0030);
    check("stray_ack_halt", 32'(halted), 0);
    check("stray_ack_pc", 32'(pc), 32'(pc_m));
`ifdef SISC_IFETCH_TIMEOUT_EN
    fetch_go = 1;
    step();
    fetch_go = 0;
    for (int i = 0; i < 15; i++) begin
      check("to_busy", 32'(busy), 1);
      step();
    end
    check("to_busy_off", 32'(busy), 0);
    check("to_err", 32'(fetch_err), 1);
    check("to_ir", ir, 0);
    check("to_valid", 32'(ir_valid), 1);
    check("to_pc", 32'(pc), 32'(pc_m));
    check("to_req", 32'(imem_req), 0);
`endif
    fetch(32'hF000_0000, 0);
    check("halted", 32'(halted), 1);
    fetch_go = 1;
    step();
    fetch_go = 0;
    check("halt_req", 32'(imem_req), 0);
    check("halt_busy", 32'(busy), 0);
    step();
    check("halt_req2", 32'(imem_req), 0);
    rst_f = 0;
    #2;
    check("rst_clr_halt", 32'(halted), 0);
    check("rst_clr_pc", 32'(pc), 0);
    step();
    rst_f = 1;
    pc_m = 0;
    step();
    fetch_go = 1;
    step();
    fetch_go = 0;
    check("mid_req", 32'(imem_req), 1);
    #2 rst_f = 0;
    #1 check("async_req", 32'(imem_req), 0);
    step();
    rst_f = 1;
    imem_ack = 1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 0;
    check("late_ack_ir", ir, 0);
    check("late_ack_valid", 32'(ir_valid), 0);
    check("late_ack_pc", 32'(pc), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
